decim_ctrl_block: RTL and testbench
===================================

Name: decim_ctrl_block

Overview:
Control/address generator for a single-MAC decimating FIR, the decimation counterpart of the single-MAC interpolator controller. Each input strobe writes one sample into a circular data RAM. Every DecimationK-th sample triggers one full FilterLength-tap MAC pass over the newest samples, and the block emits one output-valid pulse per pass. It drives the data RAM write/read addresses, the coefficient ROM address and the accumulator restart, matching the existing datapath's 2-cycle address-to-product pipeline.

Parameters:
FilterLength, 16, number of taps (>=2)
DecimationK, 2, decimation factor (>=1)
AddrWidth, 5, data RAM address width; requires 2**AddrWidth >= FilterLength + DecimationK; coeff address also AddrWidth bits

Ports:
Clk_i  in  1  clock, all logic on rising edge
Rst_i  in  1  reset, synchronous, active-high
DataNd_i  in  1  new input sample strobe; the sample is written at DataAddrWr_o this cycle
DataAddrWr_o  out  AddrWidth  data RAM write address
DataAddr_o  out  AddrWidth  data RAM read address
CoeffAddr_o  out  AddrWidth  coefficient ROM address
StartAcc_o  out  1  accumulator restart, aligned to tap-0 product
DataValid_o  out  1  one-cycle pulse: accumulator holds a finished output
Overrun_o  out  1  sticky: a trigger arrived while a pass was in progress

Behaviour:
- Reset (Rst_i=1 at a clock edge): state IDLE; addrWr, dataAddr, coeffAddr, phase counter, pipelines and overrun flag all cleared. All outputs read 0 the cycle after reset.
- Reset mid-pass: the pass is abandoned and no DataValid_o is produced.
- Write side, independent of state: on DataNd_i, DataAddrWr_o is the write address that cycle; addrWr increments next cycle, wrapping modulo 2**AddrWidth.
- Write side, phase: phase increments on each DataNd_i and wraps at DecimationK-1 -> 0.
- Trigger: DataNd_i while phase == DecimationK-1.
- States:
 - IDLE: a trigger moves to RUN with dataAddr <= current addrWr (newest sample), coeffAddr <= 0, internal startAcc <= 1.
 - RUN, each cycle with coeffAddr < FilterLength-1: dataAddr <= dataAddr-1 (wrapping), coeffAddr <= coeffAddr+1, startAcc <= 0.
 - RUN, cycle with coeffAddr == FilterLength-1 (last tap): internal rdy <= 1 next cycle. A trigger this same cycle restarts seamlessly (stay RUN, reload as from IDLE, startAcc <= 1). Otherwise go to IDLE.
 - RUN, trigger before the last tap: the pass continues. The new sample is still written and phase still wraps, but no pass is started for this trigger and the overrun flag is set.
- Internal startAcc and rdy are each delayed by a 2-stage shift register to give StartAcc_o and DataValid_o.
- Latency, for a trigger at cycle T:
 - tap addresses presented T+1..T+FilterLength
 - StartAcc_o high at T+3
 - DataValid_o high at T+FilterLength+3, exactly one cycle
- Sustainable rate: one trigger per FilterLength cycles (input spacing >= FilterLength/DecimationK).
- DecimationK=1: every DataNd_i is a trigger.
- Default states of outputs: DataAddr_o and CoeffAddr_o hold their last value in IDLE. StartAcc_o and DataValid_o are 0 except for their pulses.

Optional Feature:
Macro DECIM_OVERRUN_EN.
- Defined: overrun flag implemented as specified. It is sticky until reset and drives Overrun_o.
- Undefined: no flag register; Overrun_o tied 0. Dropped-trigger behaviour is unchanged.

Test Plan:
- Reset, then DataNd_i at cycles 10 and 11 (defaults) -> trigger at 11; DataAddr_o 1,0,31,...,18 over cycles 12..27; CoeffAddr_o 0..15; StartAcc_o pulse at 14; DataValid_o pulse at 30; DataAddrWr_o = 2 afterwards.
- DataNd_i every 8 cycles for 64 samples -> back-to-back passes with no IDLE gap, 32 DataValid_o pulses spaced 16 cycles apart, Overrun_o stays 0.
- DataNd_i every cycle for 8 cycles from reset -> one pass started (trigger at sample 2), later triggers dropped, exactly 1 DataValid_o, Overrun_o=1 (0 with DECIM_OVERRUN_EN undefined).
- 40 DataNd_i strobes spaced 8 cycles -> DataAddrWr_o wraps 31 -> 0; read addresses across the wrap decrement 0 -> 31 correctly.
- Rst_i pulsed at cycle T+5 of a pass -> no DataValid_o; all outputs 0 at T+6; the next trigger needs DecimationK fresh strobes.
- DecimationK=1, FilterLength=4, strobe every 4 cycles -> DataValid_o for every input, 4 cycles apart, seamless restarts.

Source files
------------

// File: rtl/decim_ctrl_block.sv
`default_nettype none
// ============================================================================
// Module   : decim_ctrl_block
// Brief    : Address/control generator for a single-MAC decimating FIR.
//            Every input strobe writes one sample into a circular data RAM.
//            Every DecimationK-th strobe starts one FilterLength-tap MAC pass
//            over the newest samples. StartAcc_o and DataValid_o are delayed
//            by two cycles to line up with the address-to-product pipeline.
//            Optional macro DECIM_OVERRUN_EN adds a sticky overrun flag
//            (when undefined, Overrun_o is tied low).
// Revision : 1.0 - initial release
// ============================================================================
module decim_ctrl_block #(
  parameter int FilterLength = 16,
  parameter int DecimationK  = 2,
  parameter int AddrWidth    = 5
) (
  input  logic                 Clk_i,
  input  logic                 Rst_i,
  input  logic                 DataNd_i,
  output logic [AddrWidth-1:0] DataAddrWr_o,
  output logic [AddrWidth-1:0] DataAddr_o,
  output logic [AddrWidth-1:0] CoeffAddr_o,
  output logic                 StartAcc_o,
  output logic                 DataValid_o,
  output logic                 Overrun_o
);

  // Phase counter needs at least one bit even when every strobe triggers.
  localparam int                   c_phaseW    = (DecimationK > 1) ? $clog2(DecimationK) : 1;
  localparam logic [c_phaseW-1:0]  c_phaseLast = c_phaseW'(DecimationK - 1);
  localparam logic [AddrWidth-1:0] c_lastTap   = AddrWidth'(FilterLength - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [AddrWidth-1:0] r_addrWr;
  logic [AddrWidth-1:0] r_dataAddr;
  logic [AddrWidth-1:0] w_dataAddrNext;
  logic [AddrWidth-1:0] r_coeffAddr;
  logic [AddrWidth-1:0] w_coeffAddrNext;
  logic [c_phaseW-1:0]  r_phase;
  logic                 r_startAcc;
  logic                 w_startAccNext;
  logic                 r_rdy;
  logic                 w_rdyNext;
  logic [1:0]           r_startPipe;
  logic [1:0]           r_rdyPipe;
  logic                 w_trigger;
  logic                 w_lastTap;

  assign w_trigger = DataNd_i && (r_phase == c_phaseLast);
  assign w_lastTap = (r_coeffAddr == c_lastTap);

  // Write pointer and decimation phase advance on every strobe, regardless of the pass state.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_addrWr <= '0;
      r_phase  <= '0;
    end else if (DataNd_i) begin
      r_addrWr <= r_addrWr + 1'b1;
      r_phase  <= (r_phase == c_phaseLast) ? '0 : r_phase + 1'b1;
    end
  end

  // Next-state and tap-address sequencing; a trigger on the last tap reloads without an idle gap.
  always_comb begin
    w_stateNext     = r_state;
    w_dataAddrNext  = r_dataAddr;
    w_coeffAddrNext = r_coeffAddr;
    w_startAccNext  = 1'b0;
    w_rdyNext       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_stateNext     = S_RUN;
          w_dataAddrNext  = r_addrWr;
          w_coeffAddrNext = '0;
          w_startAccNext  = 1'b1;
        end
      end
      S_RUN: begin
        if (!w_lastTap) begin
          w_dataAddrNext  = r_dataAddr - 1'b1;
          w_coeffAddrNext = r_coeffAddr + 1'b1;
        end else begin
          w_rdyNext = 1'b1;
          if (w_trigger) begin
            w_dataAddrNext  = r_addrWr;
            w_coeffAddrNext = '0;
            w_startAccNext  = 1'b1;
          end else begin
            w_stateNext = S_IDLE;
          end
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // State, tap addresses and the two-stage strobe delay lines.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_state     <= S_IDLE;
      r_dataAddr  <= '0;
      r_coeffAddr <= '0;
      r_startAcc  <= 1'b0;
      r_rdy       <= 1'b0;
      r_startPipe <= '0;
      r_rdyPipe   <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_dataAddr  <= w_dataAddrNext;
      r_coeffAddr <= w_coeffAddrNext;
      r_startAcc  <= w_startAccNext;
      r_rdy       <= w_rdyNext;
      r_startPipe <= {r_startPipe[0], r_startAcc};
      r_rdyPipe   <= {r_rdyPipe[0], r_rdy};
    end
  end

`ifdef DECIM_OVERRUN_EN
  logic r_overrun;

  // Sticky record of a trigger dropped because a pass was still mid-flight.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_overrun <= 1'b0;
    end else if ((r_state == S_RUN) && w_trigger && !w_lastTap) begin
      r_overrun <= 1'b1;
    end
  end

  assign Overrun_o = r_overrun;
`else
  assign Overrun_o = 1'b0;
`endif

  assign DataAddrWr_o = r_addrWr;
  assign DataAddr_o   = r_dataAddr;
  assign CoeffAddr_o  = r_coeffAddr;
  assign StartAcc_o   = r_startPipe[1];
  assign DataValid_o  = r_rdyPipe[1];

endmodule
`default_nettype wire

// File: tb/tb_decim_ctrl_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_decim_ctrl_block
// Brief    : Self-checking bench for decim_ctrl_block (default parameters plus
//            a DecimationK=1 / FilterLength=4 instance). Expected values come
//            from a timeline model of when passes start and what they read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decim_ctrl_block;

  localparam int FL = 16;
  localparam int K  = 2;
  localparam int AW = 5;
  localparam int M  = 32;

`ifdef DECIM_OVERRUN_EN
  localparam bit OvEn = 1'b1;
`else
  localparam bit OvEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dataNd = 1'b0;
  logic          dataNd1 = 1'b0;
  logic [AW-1:0] dataAddrWr, dataAddr, coeffAddr;
  logic          startAcc, dataValid, overrun;
  logic [AW-1:0] dataAddrWr1, dataAddr1, coeffAddr1;
  logic          startAcc1, dataValid1, overrun1;

  always #5 clk = ~clk;

  decim_ctrl_block #(.FilterLength(FL), .DecimationK(K), .AddrWidth(AW)) dut (
    .Clk_i(clk), .Rst_i(rst), .DataNd_i(dataNd),
    .DataAddrWr_o(dataAddrWr), .DataAddr_o(dataAddr), .CoeffAddr_o(coeffAddr),
    .StartAcc_o(startAcc), .DataValid_o(dataValid), .Overrun_o(overrun)
  );

  decim_ctrl_block #(.FilterLength(4), .DecimationK(1), .AddrWidth(AW)) dut1 (
    .Clk_i(clk), .Rst_i(rst), .DataNd_i(dataNd1),
    .DataAddrWr_o(dataAddrWr1), .DataAddr_o(dataAddr1), .CoeffAddr_o(coeffAddr1),
    .StartAcc_o(startAcc1), .DataValid_o(dataValid1), .Overrun_o(overrun1)
  );

  int nChk = 0;
  int nErr = 0;
  int mc   = 0;

  // Reference model state: samples since reset, most recent accepted pass.
  int wrCnt = 0, nSamp = 0, lastT = 0, lastA = 0;
  bit havePass = 0, ovf = 0;
  int qSa[$], qDv[$], q1Sa[$], q1Dv[$];
  int dvCnt = 0, dv1Cnt = 0;

  typedef struct {
    logic          nd;
    logic [AW-1:0] wr, addr, coeff;
    logic          sa, dv;
  } vec_t;
  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, mc, act, exp);
    end
  endtask

  // Check the current cycle against the model, apply this cycle's inputs, advance one clock.
  task automatic tick(input logic nd, input logic r, input logic nd1);
    int k;
    int eAddr, eCoeff;
    while (qSa.size() > 0 && qSa[0] < mc) void'(qSa.pop_front());
    while (qDv.size() > 0 && qDv[0] < mc) void'(qDv.pop_front());
    while (q1Sa.size() > 0 && q1Sa[0] < mc) void'(q1Sa.pop_front());
    while (q1Dv.size() > 0 && q1Dv[0] < mc) void'(q1Dv.pop_front());
    if (!havePass) begin
      eAddr = 0; eCoeff = 0;
    end else begin
      k = mc - lastT - 1;
      if (k > FL - 1) k = FL - 1;
      eAddr  = (lastA - k + M) % M;
      eCoeff = k;
    end
    chk("DataAddrWr", dataAddrWr, wrCnt % M);
    chk("DataAddr", dataAddr, eAddr);
    chk("CoeffAddr", coeffAddr, eCoeff);
    chk("StartAcc", startAcc, (qSa.size() > 0 && qSa[0] == mc));
    chk("DataValid", dataValid, (qDv.size() > 0 && qDv[0] == mc));
    chk("Overrun", overrun, OvEn && ovf);
    chk("StartAcc1", startAcc1, (q1Sa.size() > 0 && q1Sa[0] == mc));
    chk("DataValid1", dataValid1, (q1Dv.size() > 0 && q1Dv[0] == mc));
    if (dataValid === 1'b1) dvCnt++;
    if (dataValid1 === 1'b1) dv1Cnt++;

    rst = r; dataNd = nd; dataNd1 = nd1;

    if (r) begin
      wrCnt = 0; nSamp = 0; havePass = 0; ovf = 0;
      qSa.delete(); qDv.delete(); q1Sa.delete(); q1Dv.delete();
    end else begin
      if (nd) begin
        if (nSamp % K == K - 1) begin
          if (!havePass || mc >= lastT + FL) begin
            havePass = 1; lastT = mc; lastA = wrCnt % M;
            qSa.push_back(mc + 3);
            qDv.push_back(mc + FL + 3);
          end else begin
            ovf = 1;
          end
        end
        nSamp++; wrCnt++;
      end
      if (nd1) begin
        q1Sa.push_back(mc + 3);
        q1Dv.push_back(mc + 4 + 3);
      end
    end
    @(posedge clk); #1;
    mc++;
  endtask

  initial begin
    // Directed vectors for the first pass after reset (strobes at cycles 10 and 11).
    for (int i = 0; i < 22; i++) begin
      int c;
      c = 10 + i;
      vecs[i].nd = (c == 10 || c == 11);
      vecs[i].wr = (c <= 10) ? 5'd0 : (c == 11) ? 5'd1 : 5'd2;
      if (c < 12) begin
        vecs[i].addr = 5'd0; vecs[i].coeff = 5'd0;
      end else if (c <= 27) begin
        vecs[i].addr  = 5'((1 - (c - 12) + 32) % 32);
        vecs[i].coeff = 5'(c - 12);
      end else begin
        vecs[i].addr = 5'd18; vecs[i].coeff = 5'd15;
      end
      vecs[i].sa = (c == 14);
      vecs[i].dv = (c == 30);
    end

    rst = 1'b1;
    @(posedge clk); #1;
    mc = 0;

    // Scenario 1: table-driven first pass.
    tick(0, 1, 0);
    for (int i = 1; i < 10; i++) tick(0, 0, 0);
    for (int i = 0; i < 22; i++) begin
      chk("vecWr", dataAddrWr, vecs[i].wr);
      chk("vecAddr", dataAddr, vecs[i].addr);
      chk("vecCoeff", coeffAddr, vecs[i].coeff);
      chk("vecStart", startAcc, vecs[i].sa);
      chk("vecValid", dataValid, vecs[i].dv);
      tick(vecs[i].nd, 0, 0);
    end

    // Scenario 2: strobe every 8 cycles, 64 samples -> 32 back-to-back passes.
    tick(0, 1, 0);
    dvCnt = 0;
    for (int s = 0; s < 64; s++) begin
      tick(1, 0, 0);
      for (int j = 0; j < 7; j++) tick(0, 0, 0);
    end
    for (int j = 0; j < 24; j++) tick(0, 0, 0);
    chk("steadyValidCount", dvCnt, 32);
    chk("steadyOverrun", overrun, 0);

    // Scenario 3: strobe every cycle -> one pass, later triggers dropped.
    tick(0, 1, 0);
    dvCnt = 0;
    for (int s = 0; s < 8; s++) tick(1, 0, 0);
    for (int j = 0; j < 30; j++) tick(0, 0, 0);
    chk("stormValidCount", dvCnt, 1);
    chk("stormOverrun", overrun, OvEn);

    // Scenario 4: 40 strobes spaced 8 -> write pointer wraps, reads decrement across 0.
    tick(0, 1, 0);
    for (int s = 0; s < 40; s++) begin
      tick(1, 0, 0);
      for (int j = 0; j < 7; j++) tick(0, 0, 0);
    end
    chk("wrapWrAddr", dataAddrWr, 40 % M);

    // Scenario 5: reset at T+5 of a pass abandons it.
    tick(0, 1, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);                           // trigger at T
    for (int j = 0; j < 4; j++) tick(0, 0, 0);
    dvCnt = 0;
    tick(0, 1, 0);                           // reset during T+5
    chk("rstMidAddr", dataAddr, 0);
    chk("rstMidCoeff", coeffAddr, 0);
    chk("rstMidWr", dataAddrWr, 0);
    for (int j = 0; j < 25; j++) tick(0, 0, 0);
    chk("rstMidNoValid", dvCnt, 0);
    tick(1, 0, 0);
    for (int j = 0; j < 5; j++) tick(0, 0, 0);
    tick(1, 0, 0);
    for (int j = 0; j < 25; j++) tick(0, 0, 0);
    chk("rstMidResume", dvCnt, 1);

    // Scenario 6: K=1, FL=4 instance, strobe every 4 cycles -> one output per input.
    tick(0, 1, 0);
    dv1Cnt = 0;
    for (int s = 0; s < 8; s++) begin
      tick(0, 0, 1);
      for (int j = 0; j < 3; j++) tick(0, 0, 0);
    end
    for (int j = 0; j < 10; j++) tick(0, 0, 0);
    chk("k1ValidCount", dv1Cnt, 8);
    chk("k1WrAddr", dataAddrWr1, 8);
    chk("k1Overrun", overrun1, 0);

    // Scenario 7: random strobe densities with occasional resets.
    tick(0, 1, 0);
    for (int blk = 0; blk < 4; blk++) begin
      int p;
      p = (blk == 0) ? 10 : (blk == 1) ? 30 : (blk == 2) ? 60 : 100;
      for (int j = 0; j < 500; j++) begin
        if ($urandom_range(0, 299) == 0) tick(0, 1, 0);
        else tick(($urandom_range(0, 99) < p), 0, 0);
      end
    end
    for (int j = 0; j < 25; j++) tick(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
`default_nettype wire
